// File: rtl/edge_arb_pkg.sv
// edge_arb_pkg: shared FSM state type and default channel count for the edge event arbiter
package edge_arb_pkg;

    localparam int N_CH_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/edge_capture.sv
// edge_capture: per-channel rising-edge detect with pending and sticky overflow tracking
module edge_capture (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    input  logic en,
    input  logic clr,
    input  logic ovf_clr,
    output logic cap,
    output logic pending,
    output logic ovf
);

    logic prev_q, prev_d;
    logic pending_q, pending_d;
    logic ovf_q, ovf_d;

    // A captured edge re-arms pending even when this cycle's handshake clears it; a set overflow beats a clear
    always_comb begin
        cap       = din & ~prev_q & en;
        prev_d    = din;
        pending_d = (pending_q & ~clr) | cap;
        ovf_d     = (cap & pending_q & ~clr) | (ovf_q & ~ovf_clr);
    end

    // Capture state, cleared asynchronously
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pending = pending_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: captures enabled rising edges and offers them one at a time in round-robin order
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter  int N_CH = N_CH_DEF,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [N_CH-1:0] din,
    input  logic [N_CH-1:0] en,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CH_W-1:0] evt_ch,
    output logic [N_CH-1:0] ovf,
    input  logic            ovf_clr
);

    arb_state_t      state_q, state_d;
    logic [CH_W-1:0] sel_q, sel_d;
    logic [CH_W-1:0] rr_q, rr_d;
    logic [N_CH-1:0] pend, cap, clr, others;
    logic            hs;

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
        return (c == CH_W'(N_CH - 1)) ? '0 : c + 1'b1;
    endfunction

    function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] req, input logic [CH_W-1:0] start);
        logic [CH_W-1:0] w;
        logic            hit;
        int              idx;
        w   = '0;
        hit = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (int'(start) + i) % N_CH;
            if (!hit && req[idx]) begin
                w   = CH_W'(idx);
                hit = 1'b1;
            end
        end
        return w;
    endfunction

    for (genvar g = 0; g < N_CH; g++) begin : g_cap
        edge_capture u_cap (
            .clk     (clk),
            .resetn  (resetn),
            .din     (din[g]),
            .en      (en[g]),
            .clr     (clr[g]),
            .ovf_clr (ovf_clr),
            .cap     (cap[g]),
            .pending (pend[g]),
            .ovf     (ovf[g])
        );
    end

    // Offer FSM: pick from registered pending in IDLE, chain straight to the next winner on handshake
    always_comb begin
        hs      = (state_q == OFFER) && evt_ready;
        clr     = hs ? (N_CH'(1) << sel_q) : '0;
        others  = (pend | cap) & ~(N_CH'(1) << sel_q);
        rr_d    = hs ? next_ch(sel_q) : rr_q;
        state_d = state_q;
        sel_d   = sel_q;
        if (state_q == IDLE && |pend) begin
            sel_d   = rr_pick(pend, rr_q);
            state_d = OFFER;
        end else if (hs) begin
            sel_d   = |others ? rr_pick(others, next_ch(sel_q)) : sel_q;
            state_d = |others ? OFFER : IDLE;
        end
    end

    // Arbiter state; reset abandons any outstanding offer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
        end
    end

    assign evt_valid = (state_q == OFFER);
    assign evt_ch    = sel_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed self-checking bench for edge_event_arbiter
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] din;
    logic [3:0] en;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic [3:0] ovf;
    logic       ovf_clr;
    int         n_run = 0;
    int         n_fail = 0;

    edge_event_arbiter #(.N_CH(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .din       (din),
        .en        (en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        din    = '0;
        step();
        step();
        resetn = 1'b1;
    endtask

    initial begin
        resetn    = 1'b0;
        din       = '0;
        en        = 4'hF;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        #1;
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_ch", 32'(evt_ch), 0);
        chk("rst_ovf", 32'(ovf), 0);
        step();
        step();
        resetn = 1'b1;
        step();

        // single edge, one-cycle offer
        evt_ready = 1'b1;
        din = 4'b0100;
        step();
        chk("t1_lat", 32'(evt_valid), 0);
        step();
        chk("t1_valid", 32'(evt_valid), 1);
        chk("t1_ch", 32'(evt_ch), 2);
        step();
        chk("t1_done", 32'(evt_valid), 0);
        din = '0;

        // all channels at once from rr=0
        do_reset();
        step();
        din = 4'hF;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_valid", 32'(evt_valid), 1);
            chk("t2_ch", 32'(evt_ch), 32'(i));
        end
        step();
        chk("t2_idle", 32'(evt_valid), 0);
        din = '0;
        step();

        // double edge merges and flags overflow
        evt_ready = 1'b0;
        din = 4'b0010;
        step();
        din = '0;
        step();
        chk("t3_valid", 32'(evt_valid), 1);
        chk("t3_ch", 32'(evt_ch), 1);
        din = 4'b0010;
        step();
        chk("t3_ovf", 32'(ovf), 4'h2);
        din = '0;
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t3_ovfclr", 32'(ovf), 0);
        chk("t3_hold", 32'(evt_ch), 1);
        evt_ready = 1'b1;
        step();
        chk("t3_single", 32'(evt_valid), 0);

        // masked channel dropped
        en = 4'hB;
        din = 4'b0100;
        step();
        step();
        chk("t4_masked", 32'(evt_valid), 0);
        chk("t4_ovf", 32'(ovf), 0);
        din = 4'b1100;
        step();
        step();
        chk("t4_valid", 32'(evt_valid), 1);
        chk("t4_ch", 32'(evt_ch), 3);
        step();
        chk("t4_done", 32'(evt_valid), 0);
        din = '0;
        en = 4'hF;
        step();

        // reset mid-offer, din held high through release
        evt_ready = 1'b0;
        din = 4'b0010;
        step();
        step();
        chk("t5_offer", 32'(evt_ch), 1);
        resetn = 1'b0;
        #1;
        chk("t5_async_valid", 32'(evt_valid), 0);
        chk("t5_async_ch", 32'(evt_ch), 0);
        chk("t5_async_ovf", 32'(ovf), 0);
        step();
        step();
        resetn = 1'b1;
        step();
        chk("t5_lat", 32'(evt_valid), 0);
        step();
        chk("t5_valid", 32'(evt_valid), 1);
        chk("t5_ch", 32'(evt_ch), 1);
        evt_ready = 1'b1;
        step();
        chk("t5_done", 32'(evt_valid), 0);
        step();
        chk("t5_once", 32'(evt_valid), 0);
        din = '0;
        step();

        // handshake on ch0 coincides with a new ch0 edge (rr=2 here)
        evt_ready = 1'b0;
        din = 4'b0001;
        step();
        din = '0;
        step();
        chk("t6_ch0", 32'(evt_ch), 0);
        din = 4'b0010;
        step();
        din = 4'b0001;
        evt_ready = 1'b1;
        step();
        din = '0;
        chk("t6_next_valid", 32'(evt_valid), 1);
        chk("t6_next_ch", 32'(evt_ch), 1);
        chk("t6_no_ovf", 32'(ovf), 0);
        step();
        chk("t6_again", 32'(evt_ch), 0);
        chk("t6_again_valid", 32'(evt_valid), 1);
        step();
        chk("t6_idle", 32'(evt_valid), 0);

        // overflow set wins over a same-cycle clear
        evt_ready = 1'b0;
        din = 4'b0001;
        step();
        din = '0;
        step();
        chk("t7_offer", 32'(evt_valid), 1);
        din = 4'b0001;
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        din = '0;
        chk("t7_setwins", 32'(ovf), 4'h1);
        evt_ready = 1'b1;
        step();
        chk("t7_done", 32'(evt_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter N_CH, default 4, number of monitored input channels (2..16).
REQ-002 Parameter CH_W, default $clog2(N_CH), channel-index width, derived and not overridden.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 resetn  input  1  reset; asynchronous assert, active-low.
REQ-005 din  input  N_CH  per-channel level inputs, synchronous to clk.
REQ-006 en  input  N_CH  per-channel enable mask; 1 = edges on that channel are captured.
REQ-007 evt_valid  output  1  event offer to consumer.
REQ-008 evt_ready  input  1  consumer accept.
REQ-009 evt_ch  output  CH_W  index of offered channel; meaningful only while evt_valid=1.
REQ-010 ovf  output  N_CH  sticky per-channel overflow flags.
REQ-011 ovf_clr  input  1  single-cycle pulse clearing all ovf bits.

Function
REQ-012 Rising edge on channel i at posedge k SHALL mean din[i]=1 sampled at k and din[i]=0 sampled at k-1; prev-sample register resets to 0, so din[i] held 1 through reset release yields one edge at the first posedge after release.
REQ-013 Edge on channel i with en[i]=1 SHALL set pending[i] at that posedge; with en[i]=0 the edge SHALL be dropped; en SHALL NOT clear an already-set pending bit.
REQ-014 Handshake SHALL occur on a posedge where evt_valid=1 and evt_ready=1; it SHALL clear pending[evt_ch].
REQ-015 Edge and handshake clearing the same channel in one cycle: pending SHALL remain 1, no ovf.
REQ-016 Edge on channel i while pending[i]=1 and not cleared that cycle SHALL set ovf[i]; the event is merged, not queued.
REQ-017 ovf_clr and a new ovf set on the same bit in one cycle: set SHALL win.
REQ-018 FSM states IDLE and OFFER; evt_valid=1 exactly in OFFER.
REQ-019 IDLE: if any pending bit is set, SHALL latch round-robin winner into sel and go to OFFER; else stay.
REQ-020 OFFER: evt_ch=sel, stable until handshake; evt_valid SHALL NOT drop without handshake.
REQ-021 OFFER with handshake: if another pending bit (excluding sel, including edges set this cycle) exists, SHALL latch next winner and stay in OFFER (back-to-back, no bubble); else go to IDLE.
REQ-022 Round-robin: search starts at pointer rr, ascending modulo N_CH; after handshake on channel c, rr SHALL become (c+1) mod N_CH; rr unchanged otherwise.
REQ-023 Latency: edge at posedge k from IDLE SHALL give evt_valid=1 after posedge k+1.
REQ-024 Fairness: a pending channel SHALL be offered within N_CH handshakes.

Reset
REQ-025 While resetn=0, immediately and asynchronously: evt_valid=0, evt_ch=0, ovf=0, pending=0, prev samples=0, rr=0, state IDLE.
REQ-026 Reset asserted while in OFFER SHALL abandon the offer; no handshake is counted.
REQ-027 First state change after resetn deassertion SHALL occur on the next posedge.

Structure
REQ-028 Package edge_arb_pkg SHALL hold the FSM state enum (IDLE, OFFER) and the N_CH default constant.
REQ-029 Per-channel capture (prev sample, pending, ovf) SHALL be sub-module edge_capture, instantiated N_CH times by generate.
REQ-030 Round-robin select SHALL be a function in the top module, not a separate module.

Verification
REQ-031 N_CH=4, en=4'hF, din[2] 0->1, evt_ready=1 -> evt_valid=1, evt_ch=2 after posedge k+1; one cycle only.
REQ-032 din 4'h0->4'hF same cycle, evt_ready=1, rr=0 -> evt_ch 0,1,2,3 on four consecutive cycles, then evt_valid=0.
REQ-033 din[1] pulsed twice (0-1-0-1) with evt_ready=0 -> single offer ch 1, ovf=4'h2; ovf_clr pulse -> ovf=4'h0.
REQ-034 en=4'hB, edge on ch 2 -> no offer, ovf unchanged; edge on ch 3 -> evt_ch=3.
REQ-035 resetn low mid-OFFER (evt_ch=1, evt_ready=0) -> evt_valid=0 before next posedge; all outputs 0; din held 1 through release -> one event offered.
REQ-036 Handshake on ch 0 same cycle as new edge on ch 0 -> pending[0] stays, ch 0 offered again after other pending channels, ovf[0]=0.
